// File: rtl/satellite_uart_tx.sv
// satellite_uart_tx: AXI-Stream byte FIFO feeding an async UART serialiser
// (start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits).
module satellite_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_areset,
   input  logic [7:0]                    s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          tx_enable,
   output logic                          satellite_uart_0_txd,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(STOP_BITS * CLKS_PER_BIT);

   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
   localparam logic          ODD_POL   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // FIFO storage and control
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic [LW-1:0] level_next;
   logic [7:0]    head;
   logic          push;
   logic          pop;
   logic          fifo_empty;

   // Serialiser
   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          par_bit;
   logic          txd_r;
   logic          bit_done;

   assign push       = s_axis_tvalid & s_axis_tready;
   assign fifo_empty = (level == '0);
   assign head       = mem[rd_ptr];
   assign bit_done   = (cnt == '0);

   assign satellite_uart_0_txd = txd_r;
   assign tx_busy              = (state != ST_IDLE);
   assign fifo_level           = level;

   // Pop the head byte whenever a new frame is launched (from IDLE or straight out of STOP)
   always_comb begin
      pop = 1'b0;
      if (!fifo_empty && tx_enable) begin
         if (state == ST_IDLE)
            pop = 1'b1;
         else if (state == ST_STOP && bit_done)
            pop = 1'b1;
      end
   end

   // Next FIFO occupancy; simultaneous push and pop cancel out
   always_comb begin
      level_next = level;
      if (push && !pop)
         level_next = level + 1'b1;
      else if (pop && !push)
         level_next = level - 1'b1;
   end

   // Byte storage: no reset needed, validity is tracked by the pointers
   always_ff @(posedge s_axi_aclk) begin
      if (push)
         mem[wr_ptr] <= s_axis_tdata;
   end

   // FIFO pointers, occupancy and registered ready (= not full)
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         s_axis_tready <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         level         <= level_next;
         s_axis_tready <= (level_next != FULL_LVL);
      end
   end

   // Frame FSM with bit-period down-counter; txd is registered from the current state,
   // so the line trails the state by one cycle while every bit keeps its full width
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         txd_r   <= 1'b1;
      end else begin
         case (state)
            ST_IDLE:   txd_r <= 1'b1;
            ST_START:  txd_r <= 1'b0;
            ST_DATA:   txd_r <= shreg[0];
            ST_PARITY: txd_r <= par_bit;
            default:   txd_r <= 1'b1;
         endcase

         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state   <= ST_START;
                  cnt     <= BIT_LOAD;
                  shreg   <= head;
                  par_bit <= (^head) ^ ODD_POL;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  state   <= ST_DATA;
                  cnt     <= BIT_LOAD;
                  bit_idx <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  shreg <= {1'b0, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     if (PARITY_EN != 0) begin
                        state <= ST_PARITY;
                        cnt   <= BIT_LOAD;
                     end else begin
                        state <= ST_STOP;
                        cnt   <= STOP_LOAD;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     cnt     <= BIT_LOAD;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  state <= ST_STOP;
                  cnt   <= STOP_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  if (pop) begin
                     state   <= ST_START;
                     cnt     <= BIT_LOAD;
                     shreg   <= head;
                     par_bit <= (^head) ^ ODD_POL;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
